// File: rtl/scoreboard_register_file.sv
// Register file with r0 hardwired to zero, sensor-loaded registers, a
// single-cycle ALU write port and a long-latency write port whose pending
// destinations are tracked by a scoreboard that raises stall on hazards.
//
// Handshake: there is no valid/ready pair. stall is the only back-pressure.
// In any cycle where stall=1, writeEnable and issueEnable are ignored and the
// producer must hold the instruction. longWriteEnable and sensorValid are
// never back-pressured and always take effect.
module scoreboard_register_file #(
  parameter int REGISTER_WIDTH      = 8,
  parameter int NUMBER_OF_REGISTERS = 16,
  parameter int LOG_OF_REGISTERS    = 4,
  parameter int SENSOR_CHANNELS     = 2,
  parameter int SENSOR_BASE         = 9,
  localparam int CH_P = (SENSOR_CHANNELS > 0) ? SENSOR_CHANNELS : 1
) (
  input  logic                                 clock,
  input  logic                                 isResetN,
  input  logic [LOG_OF_REGISTERS-1:0]          readAddr1,
  input  logic [LOG_OF_REGISTERS-1:0]          readAddr2,
  output logic [REGISTER_WIDTH-1:0]            readValue1,
  output logic [REGISTER_WIDTH-1:0]            readValue2,
  input  logic                                 writeEnable,
  input  logic [LOG_OF_REGISTERS-1:0]          writeAddr,
  input  logic [REGISTER_WIDTH-1:0]            writeValue,
  input  logic                                 issueEnable,
  input  logic [LOG_OF_REGISTERS-1:0]          issueAddr,
  input  logic                                 longWriteEnable,
  input  logic [LOG_OF_REGISTERS-1:0]          longWriteAddr,
  input  logic [REGISTER_WIDTH-1:0]            longWriteValue,
  input  logic [CH_P*REGISTER_WIDTH-1:0]       sensorIn,
  input  logic [CH_P-1:0]                      sensorValid,
  output logic                                 stall,
  output logic [NUMBER_OF_REGISTERS-1:0]       pendingMask,
  output logic                                 protocolError
);

  localparam int W    = REGISTER_WIDTH;
  localparam int NREG = NUMBER_OF_REGISTERS;
  localparam int LOG  = LOG_OF_REGISTERS;
  localparam logic [LOG:0] NREG_L = NUMBER_OF_REGISTERS[LOG_OF_REGISTERS:0];

  logic [W-1:0]    r_regs [NREG];
  logic [NREG-1:0] r_pending;
  logic            r_protocol_error;

  logic            w_long_accept;
  logic            w_alu_accept;
  logic            w_alu_commit;
  logic            w_issue_accept;
  logic            w_stall;
  logic [NREG-1:0] w_pending_next;
  logic [W-1:0]    w_read1;
  logic [W-1:0]    w_read2;

  // Writable means a real register that is neither r0 nor sensor-owned.
  function automatic logic is_writable(input logic [LOG-1:0] a);
    logic in_range;
    logic in_sensor;
    in_range  = ({1'b0, a} < NREG_L);
    in_sensor = (int'(a) >= SENSOR_BASE) && (int'(a) < SENSOR_BASE + SENSOR_CHANNELS);
    return in_range && (a != '0) && !in_sensor;
  endfunction

  // A pending register is a hazard unless its long result lands this cycle.
  function automatic logic hazard(input logic [NREG-1:0] pend,
                                  input logic [LOG-1:0]  a,
                                  input logic            lwe,
                                  input logic [LOG-1:0]  lwa);
    if (!is_writable(a)) return 1'b0;
    return pend[a] && !(lwe && (lwa == a));
  endfunction

  // Read mux with forwarding: long write beats accepted ALU write beats array.
  function automatic logic [W-1:0] read_port(input logic [LOG-1:0] a,
                                             input logic [W-1:0]   arr_val);
    if (!isResetN || !is_writable(a)) begin
      if (!isResetN || (a == '0) || ({1'b0, a} >= NREG_L)) return '0;
      return arr_val;
    end
    if (w_long_accept && (longWriteAddr == a)) return longWriteValue;
    if (w_alu_accept && (writeAddr == a)) return writeValue;
    return arr_val;
  endfunction

  // Hazard detection and acceptance of the back-pressured ports.
  always_comb begin
    w_long_accept  = longWriteEnable && is_writable(longWriteAddr);
    w_stall        = hazard(r_pending, readAddr1, longWriteEnable, longWriteAddr)
                   | hazard(r_pending, readAddr2, longWriteEnable, longWriteAddr)
                   | (writeEnable && hazard(r_pending, writeAddr, longWriteEnable, longWriteAddr))
                   | (issueEnable && hazard(r_pending, issueAddr, longWriteEnable, longWriteAddr));
    w_alu_accept   = writeEnable && !w_stall && is_writable(writeAddr);
    w_alu_commit   = w_alu_accept && !(w_long_accept && (longWriteAddr == writeAddr));
    w_issue_accept = issueEnable && !w_stall && is_writable(issueAddr);
  end

  // Scoreboard update: completion clears, a same-cycle issue re-reserves.
  always_comb begin
    w_pending_next = r_pending;
    if (w_long_accept)  w_pending_next[longWriteAddr] = 1'b0;
    if (w_issue_accept) w_pending_next[issueAddr]     = 1'b1;
  end

  // Combinational read ports.
  always_comb begin
    w_read1 = read_port(readAddr1, r_regs[readAddr1]);
    w_read2 = read_port(readAddr2, r_regs[readAddr2]);
  end

  // Register array: ALU write, long write (wins on collision), sensor loads.
  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      if (w_alu_commit)  r_regs[writeAddr]     <= writeValue;
      if (w_long_accept) r_regs[longWriteAddr] <= longWriteValue;
      for (int c = 0; c < SENSOR_CHANNELS; c++) begin
        if (sensorValid[c]) r_regs[SENSOR_BASE + c] <= sensorIn[c*W +: W];
      end
    end
  end

  // Pending scoreboard and sticky error for completions nobody reserved.
  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      r_pending        <= '0;
      r_protocol_error <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      if (w_long_accept && !r_pending[longWriteAddr]) r_protocol_error <= 1'b1;
    end
  end

  assign readValue1    = w_read1;
  assign readValue2    = w_read2;
  assign stall         = w_stall;
  assign pendingMask   = r_pending;
  assign protocolError = r_protocol_error;

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Bench for scoreboard_register_file: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_scoreboard_register_file;

  // ---------------- clock / reset ----------------
  logic        clock    = 1'b0;
  logic        isResetN = 1'b0;
  always #5 clock = ~clock;

  logic [3:0]  readAddr1, readAddr2, writeAddr, issueAddr, longWriteAddr;
  logic [7:0]  readValue1, readValue2, writeValue, longWriteValue;
  logic        writeEnable, issueEnable, longWriteEnable;
  logic [15:0] sensorIn;
  logic [1:0]  sensorValid;
  logic        stall, protocolError;
  logic [15:0] pendingMask;

  scoreboard_register_file dut (
    .clock(clock), .isResetN(isResetN),
    .readAddr1(readAddr1), .readAddr2(readAddr2),
    .readValue1(readValue1), .readValue2(readValue2),
    .writeEnable(writeEnable), .writeAddr(writeAddr), .writeValue(writeValue),
    .issueEnable(issueEnable), .issueAddr(issueAddr),
    .longWriteEnable(longWriteEnable), .longWriteAddr(longWriteAddr),
    .longWriteValue(longWriteValue),
    .sensorIn(sensorIn), .sensorValid(sensorValid),
    .stall(stall), .pendingMask(pendingMask), .protocolError(protocolError)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_regs [16];
  logic [15:0] m_pend;
  logic        m_err;

  function automatic bit m_writable(int a);
    return (a != 0) && !(a >= 9 && a < 11);
  endfunction

  function automatic bit m_hz(int a);
    return m_pend[a] && !(longWriteEnable && int'(longWriteAddr) == a);
  endfunction

  function automatic bit m_stall();
    return m_hz(int'(readAddr1)) || m_hz(int'(readAddr2))
        || (writeEnable && m_hz(int'(writeAddr)))
        || (issueEnable && m_hz(int'(issueAddr)));
  endfunction

  function automatic logic [7:0] m_read(int a);
    if (!isResetN || a == 0) return 8'h00;
    if (m_writable(a) && longWriteEnable && int'(longWriteAddr) == a) return longWriteValue;
    if (m_writable(a) && writeEnable && !m_stall() && int'(writeAddr) == a) return writeValue;
    return m_regs[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_pend = 16'h0;
    m_err  = 1'b0;
  endtask

  task automatic m_step();
    bit st;
    int wa, la, ia;
    st = m_stall();
    wa = int'(writeAddr);
    la = int'(longWriteAddr);
    ia = int'(issueAddr);
    if (writeEnable && !st && m_writable(wa)) m_regs[wa] = writeValue;
    if (longWriteEnable && m_writable(la)) begin
      if (!m_pend[la]) m_err = 1'b1;
      m_regs[la] = longWriteValue;
      m_pend[la] = 1'b0;
    end
    if (issueEnable && !st && m_writable(ia)) m_pend[ia] = 1'b1;
    for (int c = 0; c < 2; c++) if (sensorValid[c]) m_regs[9 + c] = sensorIn[c*8 +: 8];
  endtask

  always @(negedge isResetN) m_reset();
  always @(posedge clock) begin
    if (!isResetN) m_reset();
    else m_step();
  end

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    chk("readValue1", 32'(readValue1), 32'(m_read(int'(readAddr1))));
    chk("readValue2", 32'(readValue2), 32'(m_read(int'(readAddr2))));
    chk("stall", 32'(stall), 32'(m_stall()));
    chk("pendingMask", 32'(pendingMask), 32'(m_pend));
    chk("protocolError", 32'(protocolError), 32'(m_err));
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    readAddr1 = 0; readAddr2 = 0;
    writeEnable = 0; writeAddr = 0; writeValue = 0;
    issueEnable = 0; issueAddr = 0;
    longWriteEnable = 0; longWriteAddr = 0; longWriteValue = 0;
    sensorIn = 0; sensorValid = 0;
  endtask

  task automatic settle();
    @(negedge clock); #1;
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic rand_cycle();
    int cand[$];
    readAddr1   = 4'($urandom_range(0, 15));
    readAddr2   = 4'($urandom_range(0, 15));
    writeEnable = 1'($urandom_range(0, 1));
    writeAddr   = 4'($urandom_range(0, 15));
    writeValue  = 8'($urandom);
    issueEnable = ($urandom_range(0, 3) == 0);
    issueAddr   = 4'($urandom_range(0, 15));
    longWriteEnable = ($urandom_range(0, 2) == 0);
    longWriteAddr   = 4'($urandom_range(0, 15));
    longWriteValue  = 8'($urandom);
    for (int i = 0; i < 16; i++) if (m_pend[i]) cand.push_back(i);
    if (cand.size() > 0 && $urandom_range(0, 4) != 0)
      longWriteAddr = 4'(cand[$urandom_range(0, cand.size() - 1)]);
    sensorIn    = 16'($urandom);
    sensorValid = 2'($urandom_range(0, 3));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_reset();
    idle();
    repeat (3) @(posedge clock);
    settle();
    chk("rst_pending", 32'(pendingMask), 32'h0);
    chk("rst_error", 32'(protocolError), 32'h0);
    chk("rst_read", 32'(readValue1), 32'h0);
    tick();
    isResetN = 1'b1;

    // Reset mid-run clears array and scoreboard immediately.
    writeEnable = 1; writeAddr = 3; writeValue = 8'd5;
    issueEnable = 1; issueAddr = 7; readAddr1 = 3;
    settle();
    chk("t1_fwd_r3", 32'(readValue1), 32'd5);
    tick();
    idle(); readAddr1 = 3;
    settle();
    chk("t1_r3", 32'(readValue1), 32'd5);
    chk("t1_pend", 32'(pendingMask), 32'h0080);
    isResetN = 1'b0;
    #1;
    chk("t1_async_r3", 32'(readValue1), 32'd0);
    chk("t1_async_pend", 32'(pendingMask), 32'h0);
    tick();
    isResetN = 1'b1;

    // ALU write r1=-7, write to r0 dropped.
    idle();
    writeEnable = 1; writeAddr = 1; writeValue = 8'hF9; readAddr1 = 1;
    settle();
    chk("t2_fwd_r1", 32'(readValue1), 32'hF9);
    tick();
    writeAddr = 0; writeValue = 8'd99; readAddr2 = 0;
    settle();
    chk("t2_r1", 32'(readValue1), 32'hF9);
    chk("t2_r0_fwd", 32'(readValue2), 32'h0);
    tick();
    idle();
    settle();
    chk("t2_r0", 32'(readValue1), 32'h0);

    // Pending r5 stalls; dropped ALU write; long write releases same cycle.
    issueEnable = 1; issueAddr = 5;
    tick();
    idle();
    readAddr1 = 5; writeEnable = 1; writeAddr = 2; writeValue = 8'h55;
    settle();
    chk("t3_stall", 32'(stall), 32'd1);
    tick();
    writeEnable = 0;
    longWriteEnable = 1; longWriteAddr = 5; longWriteValue = 8'd42; readAddr2 = 2;
    settle();
    chk("t3_release", 32'(stall), 32'd0);
    chk("t3_fwd_r5", 32'(readValue1), 32'd42);
    chk("t3_r2_dropped", 32'(readValue2), 32'd0);
    tick();
    idle(); readAddr1 = 5;
    settle();
    chk("t3_pend", 32'(pendingMask), 32'h0);
    chk("t3_r5", 32'(readValue1), 32'd42);

    // ALU and long write collide on pending r4: long write wins.
    issueEnable = 1; issueAddr = 4;
    tick();
    idle();
    writeEnable = 1; writeAddr = 4; writeValue = 8'd1;
    longWriteEnable = 1; longWriteAddr = 4; longWriteValue = 8'd2; readAddr1 = 4;
    settle();
    chk("t4_stall", 32'(stall), 32'd0);
    chk("t4_fwd_r4", 32'(readValue1), 32'd2);
    tick();
    idle(); readAddr1 = 4;
    settle();
    chk("t4_r4", 32'(readValue1), 32'd2);
    chk("t4_pend", 32'(pendingMask), 32'h0);
    chk("t4_err", 32'(protocolError), 32'd0);

    // Long write to a non-pending register sets the sticky error.
    longWriteEnable = 1; longWriteAddr = 6; longWriteValue = 8'h33;
    tick();
    idle(); readAddr1 = 6;
    settle();
    chk("t5_r6", 32'(readValue1), 32'h33);
    chk("t5_err", 32'(protocolError), 32'd1);
    repeat (3) tick();
    settle();
    chk("t5_err_sticky", 32'(protocolError), 32'd1);

    // Sensor channel 0 loads r9; ALU write to r9 and issue to r9 ignored.
    idle();
    sensorValid = 2'b01; sensorIn = {8'h77, 8'd30};
    writeEnable = 1; writeAddr = 9; writeValue = 8'd7;
    tick();
    idle(); readAddr1 = 9; readAddr2 = 10;
    settle();
    chk("t6_r9", 32'(readValue1), 32'd30);
    chk("t6_r10", 32'(readValue2), 32'd0);
    issueEnable = 1; issueAddr = 9;
    tick();
    idle();
    settle();
    chk("t6_pend", 32'(pendingMask), 32'h0);

    isResetN = 1'b0;
    #1;
    chk("rst_clears_err", 32'(protocolError), 32'd0);
    tick();
    isResetN = 1'b1;

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rand_cycle();
      if ($urandom_range(0, 249) == 0) isResetN = 1'b0;
      tick();
      isResetN = 1'b1;
    end
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
